// File: rtl/mont_almost_inv.sv
// mont_almost_inv: Kaliski phase-1 almost Montgomery inverse.
// Produces r = a^-1 * 2^k mod p and the iteration count k, one iteration per cycle.
`default_nettype none

module mont_almost_inv #(
    parameter int WIDTH = 256,
    parameter int CWID  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] mod,
    input  logic             en,
    output logic [WIDTH-1:0] inv,
    output logic [CWID-1:0]  exp,
    output logic             vld,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOOP = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] u_q, u_d, v_q, v_d, mod_q, mod_d, inv_q, inv_d;
    logic [WIDTH:0]   r_q, r_d, s_q, s_d;
    logic [CWID-1:0]  k_q, k_d, exp_q, exp_d;
    logic             vld_q, vld_d, busy_q, busy_d, err_q, err_d, bad_q, bad_d;

    logic             w_bad;
    logic             w_u_gt;
    logic [WIDTH-1:0] w_uv, w_vu;
    logic [WIDTH:0]   w_rs, w_rsub, w_rred;

    assign w_bad  = (a == '0) || !mod[0];
    assign w_u_gt = u_q > v_q;
    assign w_uv   = u_q - v_q;
    assign w_vu   = v_q - u_q;
    assign w_rs   = r_q + s_q;
    assign w_rsub = r_q - {1'b0, mod_q};
    assign w_rred = (r_q >= {1'b0, mod_q}) ? w_rsub : r_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a new start pulse overrides every state
    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = S_LOOP;
        end else begin
            case (state_q)
                S_LOOP:  if (v_q == '0) state_d = S_FIN;
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        u_d   = u_q;
        v_d   = v_q;
        r_d   = r_q;
        s_d   = s_q;
        k_d   = k_q;
        mod_d = mod_q;
        bad_d = bad_q;
        inv_d = inv_q;
        exp_d = exp_q;
        err_d = err_q;
        busy_d = busy_q;
        vld_d = 1'b0;
        if (en) begin
            // Illegal operands load v=0 so the v==0 exit routes them to FIN
            // with the same two-edge latency as a zero-iteration run.
            u_d    = mod;
            v_d    = w_bad ? '0 : a;
            r_d    = '0;
            s_d    = {{WIDTH{1'b0}}, 1'b1};
            k_d    = '0;
            mod_d  = mod;
            bad_d  = w_bad;
            busy_d = 1'b1;
        end else begin
            case (state_q)
                S_LOOP: begin
                    if (v_q != '0) begin
                        k_d = k_q + CWID'(1);
                        if (!u_q[0]) begin
                            u_d = u_q >> 1;
                            s_d = s_q << 1;
                        end else if (!v_q[0]) begin
                            v_d = v_q >> 1;
                            r_d = r_q << 1;
                        end else if (w_u_gt) begin
                            u_d = w_uv >> 1;
                            r_d = w_rs;
                            s_d = s_q << 1;
                        end else begin
                            v_d = w_vu >> 1;
                            s_d = w_rs;
                            r_d = r_q << 1;
                        end
                    end
                end
                S_FIN: begin
                    vld_d  = 1'b1;
                    busy_d = 1'b0;
                    if (bad_q) begin
                        inv_d = '0;
                        exp_d = '0;
                        err_d = 1'b1;
                    end else begin
                        inv_d = WIDTH'({1'b0, mod_q} - w_rred);
                        exp_d = k_q;
                        err_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_q    <= '0;
            v_q    <= '0;
            r_q    <= '0;
            s_q    <= '0;
            k_q    <= '0;
            mod_q  <= '0;
            bad_q  <= 1'b0;
            inv_q  <= '0;
            exp_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            u_q    <= u_d;
            v_q    <= v_d;
            r_q    <= r_d;
            s_q    <= s_d;
            k_q    <= k_d;
            mod_q  <= mod_d;
            bad_q  <= bad_d;
            inv_q  <= inv_d;
            exp_q  <= exp_d;
            err_q  <= err_d;
            busy_q <= busy_d;
            vld_q  <= vld_d;
        end
    end

    assign inv  = inv_q;
    assign exp  = exp_q;
    assign vld  = vld_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mont_almost_inv.sv
// tb_mont_almost_inv: directed and randomized checks of mont_almost_inv at WIDTH=8.
`default_nettype none

module tb_mont_almost_inv;

    localparam int W  = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [W-1:0]  a;
    logic [W-1:0]  md;
    logic [W-1:0]  inv;
    logic [CW-1:0] exp;
    logic          vld, busy, err;

    int checks = 0;
    int errors = 0;

    mont_almost_inv #(.WIDTH(W), .CWID(CW)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .mod (md),
        .en  (en),
        .inv (inv),
        .exp (exp),
        .vld (vld),
        .busy(busy),
        .err (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Kaliski phase-1 reference on plain integers.
    task automatic ref_model(input int p, input int x, output int k, output int r_inv);
        int u, v, r, s;
        u = p; v = x; r = 0; s = 1; k = 0;
        while (v != 0) begin
            if (u % 2 == 0)      begin u = u / 2; s = 2 * s; end
            else if (v % 2 == 0) begin v = v / 2; r = 2 * r; end
            else if (u > v)      begin u = (u - v) / 2; r = r + s; s = 2 * s; end
            else                 begin v = (v - u) / 2; s = s + r; r = 2 * r; end
            k++;
        end
        if (r >= p) r = r - p;
        r_inv = p - r;
    endtask

    function automatic int pow2mod(input int e, input int p);
        int res = 1;
        for (int i = 0; i < e; i++) res = (res * 2) % p;
        return res;
    endfunction

    function automatic int bitlen(input int x);
        int n = 0;
        while (x > 0) begin x = x / 2; n++; end
        return n;
    endfunction

    task automatic pulse_en(input int av, input int mv);
        @(negedge clk);
        a  = W'(av);
        md = W'(mv);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        while (vld !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_one(input string tag, input int av, input int mv);
        int k, ri, n, lat, e_inv, e_exp, e_err;
        if (av == 0 || mv % 2 == 0) begin
            e_inv = 0; e_exp = 0; e_err = 1; lat = 2;
        end else begin
            ref_model(mv, av, k, ri);
            e_inv = ri; e_exp = k; e_err = 0; lat = k + 2;
        end
        pulse_en(av, mv);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_vld(n);
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_inv"}, 64'(inv), 64'(e_inv));
        check({tag, "_exp"}, 64'(exp), 64'(e_exp));
        check({tag, "_err"}, 64'(err), 64'(e_err));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        if (e_err == 0) begin
            check({tag, "_identity"}, 64'((int'(inv) * av) % mv), 64'(pow2mod(int'(exp), mv)));
            check({tag, "_exp_range"},
                  64'(int'(exp) >= bitlen(mv) && int'(exp) <= 2 * bitlen(mv)), 64'd1);
        end
        @(negedge clk);
        check({tag, "_vld_pulse"}, 64'(vld), 64'd0);
        check({tag, "_inv_hold"}, 64'(inv), 64'(e_inv));
    endtask

    int primes[$] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61, 67,
                      71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131, 137, 139,
                      149, 151, 157, 163, 167, 173, 179, 181, 191, 193, 197, 199, 211, 223,
                      227, 229, 233, 239, 241, 251};

    initial begin
        int n, seen, p, x;
        rst = 1'b1; en = 1'b0; a = '0; md = '0;
        repeat (2) @(negedge clk);
        check("rst_vld", 64'(vld), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_inv", 64'(inv), 64'd0);
        check("rst_exp", 64'(exp), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_one("m13_a1", 1, 13);
        check("m13_a1_inv_const", 64'(inv), 64'd3);
        run_one("m13_a5", 5, 13);
        check("m13_a5_exp_const", 64'(exp), 64'd6);
        run_one("m13_a0", 0, 13);
        run_one("even_mod", 5, 12);
        run_one("m13_a12", 12, 13);
        run_one("m251_a250", 250, 251);

        // Restart while looping: only the second operation completes.
        pulse_en(5, 13);
        seen = 0;
        @(negedge clk);
        if (vld === 1'b1) seen++;
        a = 8'd1; md = 8'd13; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("restart_no_early_vld", 64'(seen), 64'd0);
        wait_vld(n);
        check("restart_latency", 64'(n), 64'd6);
        check("restart_inv", 64'(inv), 64'd3);
        check("restart_exp", 64'(exp), 64'd4);

        // Start pulse landing on the FIN edge suppresses that completion.
        pulse_en(1, 13);
        seen = 0;
        repeat (5) begin
            if (vld === 1'b1) seen++;
            @(negedge clk);
        end
        a = 8'd5; md = 8'd13; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("fin_restart_no_vld", 64'(seen), 64'd0);
        wait_vld(n);
        check("fin_restart_latency", 64'(n), 64'd8);
        check("fin_restart_inv", 64'(inv), 64'd5);
        check("fin_restart_exp", 64'(exp), 64'd6);

        // Asynchronous reset mid-loop clears outputs at once and yields no vld.
        pulse_en(1, 13);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_inv", 64'(inv), 64'd0);
        check("arst_exp", 64'(exp), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_vld", 64'(vld), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (vld === 1'b1) seen++;
        end
        check("arst_no_vld", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            p = primes[$urandom_range(primes.size() - 1, 0)];
            x = int'($urandom_range(p - 1, 1));
            run_one("rand", x, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
